// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int SLICE_W = 8;

endpackage

// File: rtl/addc8_slice.sv
// Combinational 8-bit add-with-carry slice shared by every byte of an operation.
module addc8_slice
    import addsub_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] i0,
    input  logic [SLICE_W-1:0] i1,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, i0} + {1'b0, i1} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract performed one byte per clock through a single 8-bit slice,
// LSB first, with valid/ready handshakes on both sides.
module addsub_seq_ctrl
    import addsub_seq_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    I_VALID,
    output logic                    I_READY,
    input  logic                    OP,
    input  logic [SLICE_W*NSLICE-1:0] I0,
    input  logic [SLICE_W*NSLICE-1:0] I1,
    output logic                    O_VALID,
    input  logic                    O_READY,
    output logic [SLICE_W*NSLICE-1:0] O,
    output logic                    COUT,
    output logic                    V,
    output logic                    BUSY
);

    localparam int W  = SLICE_W * NSLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  o_q, o_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          v_q, v_d;

    logic [SLICE_W-1:0] s;
    logic               c;

    // Operands shift right each cycle, so the slice always sees byte 0.
    addc8_slice u_slice (
        .i0   (a_q[SLICE_W-1:0]),
        .i1   (b_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .sum  (s),
        .cout (c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        v_d     = v_q;
        unique case (state_q)
            IDLE: begin
                if (I_VALID) begin
                    a_d     = I0;
                    b_d     = (OP == OP_SUB) ? ~I1 : I1;
                    carry_d = (OP == OP_SUB);
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                o_d[idx_q*SLICE_W +: SLICE_W] = s;
                carry_d = c;
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                if (idx_q == LAST) begin
                    cout_d  = c;
                    v_d     = (a_q[SLICE_W-1] ^ s[SLICE_W-1])
                            & (b_q[SLICE_W-1] ^ s[SLICE_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (O_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            o_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign I_READY = (state_q == IDLE);
    assign O_VALID = (state_q == DONE);
    assign BUSY    = (state_q == RUN) || (state_q == DONE);
    assign O       = o_q;
    assign COUT    = cout_q;
    assign V       = v_q;

endmodule
